commit_trace_fifo: RTL and testbench
====================================

// Module: commit_trace_fifo
// PURPOSE
//  Sits directly downstream of core_model's retirement interface. Classifies each retired
//  instruction (plain / reg-write / load / store) and packs it into a fixed trace record.
//  Records go into a show-ahead FIFO; a trace sink drains it over a valid/ready handshake.
//  Detects the end-of-test self-loop (instr 32'h0000006f), drains the FIFO, then asserts done_o.
// PARAMETERS
//  XLEN      32  data/address width (riscv_pkg::XLEN)
//  DEPTH     16  FIFO entries; power of two, >= 2
//  CNT_W     16  width of drop_cnt_o
//  END_INSTR 32'h0000006f  instruction word that ends the test
// PORTS
//  clk          in   1     clock
//  rstn         in   1     reset; synchronous, active-low
//  update_i     in   1     core retired an instruction this cycle
//  pc_i         in   XLEN  retired PC
//  instr_i      in   32    retired instruction word
//  rd_i         in   5     destination register index
//  rd_data_i    in   XLEN  value written to rd
//  rf_we_i      in   1     register file write enable
//  mem_re_i     in   1     load performed
//  mem_we_i     in   1     store performed
//  mem_raddr_i  in   XLEN  load address
//  mem_waddr_i  in   XLEN  store address
//  mem_wdata_i  in   XLEN  store data (unmasked)
//  st_size_i    in   2     store size: 0 = byte, 1 = half, 2 = word
//  rec_valid_o  out  1     head record valid
//  rec_ready_i  in   1     sink accepts the head record
//  rec_kind_o   out  2     0 = PLAIN, 1 = REG, 2 = LOAD, 3 = STORE
//  rec_pc_o     out  XLEN  record PC
//  rec_instr_o  out  32    record instruction
//  rec_rd_o     out  5     rd for REG/LOAD; 0 otherwise
//  rec_data_o   out  XLEN  rd data (REG/LOAD) or masked store data (STORE); 0 for PLAIN
//  rec_addr_o   out  XLEN  memory address (LOAD/STORE); 0 otherwise
//  rec_size_o   out  2     store size for STORE; 0 otherwise
//  drop_cnt_o   out  CNT_W records lost because the FIFO was full; saturating
//  level_o      out  $clog2(DEPTH)+1  FIFO occupancy
//  done_o       out  1     end-of-test reached and trace fully drained
// BEHAVIOUR
//  Reset: FIFO empty, level_o = 0, rec_valid_o = 0, drop_cnt_o = 0, done_o = 0, FSM = RUN.
//   Reset mid-operation discards all buffered records.
//  Capture event: update_i && pc_i != 0 && state == RUN.
//  Classification, priority order:
//   - mem_we_i -> STORE
//   - mem_re_i && rd_i != 0 -> LOAD
//   - rf_we_i && rd_i != 0 -> REG
//   - otherwise -> PLAIN
//  Store data is zero-extended from its low bits: byte = [7:0], half = [15:0], word = all.
//   st_size_i = 3 is treated as word.
//  Push is accepted when the FIFO is not full, or when it is full and a pop happens in the
//   same cycle. A refused push increments drop_cnt_o, saturating at all-ones.
//  Pop: rec_valid_o && rec_ready_i at the clock edge.
//  Latency: a record captured at edge N shows rec_valid_o = 1 after edge N.
//  Record outputs are driven combinationally from the head entry and stay stable while
//   rec_valid_o = 1 and rec_ready_i = 0.
//  level_o: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
//   The read and write pointers wrap modulo DEPTH.
//  FSM:
//   - RUN -> DRAIN when a capture event has instr_i == END_INSTR. That record is still
//     pushed or counted as dropped.
//   - DRAIN: capture disabled; the sink keeps popping. DRAIN -> DONE on the edge where the
//     FIFO becomes empty, or directly if it is already empty.
//   - DONE: done_o = 1, rec_valid_o = 0, update_i ignored. Only rstn leaves DONE.
//  update_i with pc_i = 0 is never recorded and never triggers the end of test.
// TESTING
//  - ADDI retire (update=1, pc=0x80000000, rd=5, rf_we=1, data=0x10) -> 1 cycle later
//    kind=REG, rd=5, data=0x10, addr=0.
//  - SB retire with wdata=0xDEADBEEF, waddr=0x80001003 -> kind=STORE, data=0x000000EF,
//    size=0. LW with rd=0 -> kind=PLAIN.
//  - rec_ready_i=0, 20 retires with DEPTH=16 -> level_o=16, drop_cnt_o=4, first 16 records
//    in order. Full plus a push/pop in the same cycle -> drop count unchanged.
//  - Retire END_INSTR at level 3 with ready=1 -> later updates ignored, done_o=1 one cycle
//    after the last pop.
//  - Assert rstn=0 while holding 5 records -> next cycle level_o=0, rec_valid_o=0,
//    drop_cnt_o=0, FSM=RUN.
//  - Random ready toggling over 200 retires -> popped stream equals pushed stream and the
//    record stays stable while stalled.

Source files
------------

// File: rtl/commit_trace_fifo.sv
// Retirement trace capture: classifies retired instructions into fixed records,
// buffers them in a show-ahead FIFO and signals done once the end-of-test loop has drained.
module commit_trace_fifo #(
   parameter int unsigned XLEN      = 32,
   parameter int unsigned DEPTH     = 16,
   parameter int unsigned CNT_W     = 16,
   parameter logic [31:0] END_INSTR = 32'h0000006f
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic                       update_i,
   input  logic [XLEN-1:0]            pc_i,
   input  logic [31:0]                instr_i,
   input  logic [4:0]                 rd_i,
   input  logic [XLEN-1:0]            rd_data_i,
   input  logic                       rf_we_i,
   input  logic                       mem_re_i,
   input  logic                       mem_we_i,
   input  logic [XLEN-1:0]            mem_raddr_i,
   input  logic [XLEN-1:0]            mem_waddr_i,
   input  logic [XLEN-1:0]            mem_wdata_i,
   input  logic [1:0]                 st_size_i,
   output logic                       rec_valid_o,
   input  logic                       rec_ready_i,
   output logic [1:0]                 rec_kind_o,
   output logic [XLEN-1:0]            rec_pc_o,
   output logic [31:0]                rec_instr_o,
   output logic [4:0]                 rec_rd_o,
   output logic [XLEN-1:0]            rec_data_o,
   output logic [XLEN-1:0]            rec_addr_o,
   output logic [1:0]                 rec_size_o,
   output logic [CNT_W-1:0]           drop_cnt_o,
   output logic [$clog2(DEPTH):0]     level_o,
   output logic                       done_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;

   typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

   typedef struct packed {
      logic [1:0]      kind;
      logic [XLEN-1:0] pc;
      logic [31:0]     instr;
      logic [4:0]      rd;
      logic [XLEN-1:0] data;
      logic [XLEN-1:0] addr;
      logic [1:0]      size;
   } rec_t;

   state_t           state_q, state_d;
   logic [LW-1:0]    level_q, level_d;
   logic [AW-1:0]    wptr_q, rptr_q;
   logic [CNT_W-1:0] drop_q;
   rec_t             mem_q [DEPTH];
   rec_t             rec_in, head;
   logic             capture, full, pop, push, drop;

   function automatic logic [XLEN-1:0] store_mask(input logic [XLEN-1:0] d,
                                                  input logic [1:0]      sz);
      case (sz)
         2'd0:    return {{(XLEN-8){1'b0}}, d[7:0]};
         2'd1:    return {{(XLEN-16){1'b0}}, d[15:0]};
         default: return d;
      endcase
   endfunction

   always_comb begin
      rec_in       = '0;
      rec_in.pc    = pc_i;
      rec_in.instr = instr_i;
      if (mem_we_i) begin
         rec_in.kind = 2'd3;
         rec_in.addr = mem_waddr_i;
         rec_in.data = store_mask(mem_wdata_i, st_size_i);
         rec_in.size = (st_size_i == 2'd3) ? 2'd2 : st_size_i;
      end else if (mem_re_i && rd_i != 5'd0) begin
         rec_in.kind = 2'd2;
         rec_in.rd   = rd_i;
         rec_in.data = rd_data_i;
         rec_in.addr = mem_raddr_i;
      end else if (rf_we_i && rd_i != 5'd0) begin
         rec_in.kind = 2'd1;
         rec_in.rd   = rd_i;
         rec_in.data = rd_data_i;
      end
   end

   assign capture     = update_i && (pc_i != '0) && (state_q == RUN);
   assign full        = (level_q == LW'(DEPTH));
   assign rec_valid_o = (level_q != '0) && (state_q != DONE);
   assign pop         = rec_valid_o && rec_ready_i;
   // A full FIFO still takes the push when the head leaves on the same edge.
   assign push        = capture && (!full || pop);
   assign drop        = capture && !push;

   always_comb begin
      level_d = level_q;
      if (push && !pop)      level_d = level_q + LW'(1);
      else if (!push && pop) level_d = level_q - LW'(1);
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN:     if (capture && instr_i == END_INSTR) state_d = DRAIN;
         DRAIN:   if (level_d == '0) state_d = DONE;
         DONE:    state_d = DONE;
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= RUN;
         level_q <= '0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         drop_q  <= '0;
      end else begin
         state_q <= state_d;
         level_q <= level_d;
         if (push) wptr_q <= wptr_q + AW'(1);
         if (pop)  rptr_q <= rptr_q + AW'(1);
         if (drop && drop_q != '1) drop_q <= drop_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q] <= rec_in;
   end

   assign head        = mem_q[rptr_q];
   assign rec_kind_o  = head.kind;
   assign rec_pc_o    = head.pc;
   assign rec_instr_o = head.instr;
   assign rec_rd_o    = head.rd;
   assign rec_data_o  = head.data;
   assign rec_addr_o  = head.addr;
   assign rec_size_o  = head.size;
   assign drop_cnt_o  = drop_q;
   assign level_o     = level_q;
   assign done_o      = (state_q == DONE);

endmodule

// File: tb/tb_commit_trace_fifo.sv
// Directed and randomized bench for commit_trace_fifo against a queue-based record model.
module tb_commit_trace_fifo;

   localparam int DEPTH = 16;
   localparam logic [31:0] END_I = 32'h0000006f;

   typedef struct packed {
      logic [1:0]  kind;
      logic [31:0] pc;
      logic [31:0] instr;
      logic [4:0]  rd;
      logic [31:0] data;
      logic [31:0] addr;
      logic [1:0]  size;
   } rec_t;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        update_i = 1'b0;
   logic [31:0] pc_i = '0, instr_i = '0, rd_data_i = '0;
   logic [4:0]  rd_i = '0;
   logic        rf_we_i = 1'b0, mem_re_i = 1'b0, mem_we_i = 1'b0;
   logic [31:0] mem_raddr_i = '0, mem_waddr_i = '0, mem_wdata_i = '0;
   logic [1:0]  st_size_i = '0;
   logic        rec_ready_i = 1'b0;
   logic        rec_valid_o, done_o;
   logic [1:0]  rec_kind_o, rec_size_o;
   logic [31:0] rec_pc_o, rec_instr_o, rec_data_o, rec_addr_o;
   logic [4:0]  rec_rd_o;
   logic [15:0] drop_cnt_o;
   logic [4:0]  level_o;

   commit_trace_fifo dut (
      .clk(clk), .rstn(rstn), .update_i(update_i), .pc_i(pc_i), .instr_i(instr_i),
      .rd_i(rd_i), .rd_data_i(rd_data_i), .rf_we_i(rf_we_i), .mem_re_i(mem_re_i),
      .mem_we_i(mem_we_i), .mem_raddr_i(mem_raddr_i), .mem_waddr_i(mem_waddr_i),
      .mem_wdata_i(mem_wdata_i), .st_size_i(st_size_i), .rec_valid_o(rec_valid_o),
      .rec_ready_i(rec_ready_i), .rec_kind_o(rec_kind_o), .rec_pc_o(rec_pc_o),
      .rec_instr_o(rec_instr_o), .rec_rd_o(rec_rd_o), .rec_data_o(rec_data_o),
      .rec_addr_o(rec_addr_o), .rec_size_o(rec_size_o), .drop_cnt_o(drop_cnt_o),
      .level_o(level_o), .done_o(done_o)
   );

   always #5 clk = ~clk;

   int   n_vec = 0, n_err = 0;
   rec_t q[$];
   int   m_drop = 0;
   int   phase = 0;  // 0 running, 1 draining, 2 finished

   task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic rec_t dut_rec();
      return {rec_kind_o, rec_pc_o, rec_instr_o, rec_rd_o, rec_data_o, rec_addr_o, rec_size_o};
   endfunction

   function automatic rec_t model_rec();
      rec_t r = '0;
      r.pc = pc_i;
      r.instr = instr_i;
      if (mem_we_i) begin
         r.kind = 3;
         r.addr = mem_waddr_i;
         r.size = (st_size_i == 3) ? 2'd2 : st_size_i;
         r.data = (st_size_i == 0) ? (mem_wdata_i % 256) :
                  (st_size_i == 1) ? (mem_wdata_i % 65536) : mem_wdata_i;
      end else if (mem_re_i && rd_i != 0) begin
         r.kind = 2; r.rd = rd_i; r.data = rd_data_i; r.addr = mem_raddr_i;
      end else if (rf_we_i && rd_i != 0) begin
         r.kind = 1; r.rd = rd_i; r.data = rd_data_i;
      end
      return r;
   endfunction

   task automatic check_outputs();
      bit v = (q.size() > 0) && (phase != 2);
      chk("level", level_o, q.size());
      chk("valid", rec_valid_o, v);
      chk("drop", drop_cnt_o, m_drop);
      chk("done", done_o, phase == 2);
      if (v) chk("rec", dut_rec(), q[0]);
   endtask

   // One clock: predict from current inputs, advance, then compare on the falling edge.
   task automatic step();
      bit   pop, cap, push, stall;
      rec_t r, held;
      pop   = (q.size() > 0) && (phase != 2) && rec_ready_i;
      cap   = update_i && (pc_i != 0) && (phase == 0);
      push  = cap && (q.size() < DEPTH || pop);
      r     = model_rec();
      stall = rec_valid_o && !rec_ready_i && rstn;
      held  = dut_rec();
      @(posedge clk);
      if (!rstn) begin
         q.delete(); m_drop = 0; phase = 0;
      end else begin
         if (pop) void'(q.pop_front());
         if (push) q.push_back(r);
         if (cap && !push && m_drop < 65535) m_drop++;
         if (cap && instr_i == END_I) phase = 1;
         else if (phase == 1 && q.size() == 0) phase = 2;
      end
      @(negedge clk);
      check_outputs();
      if (stall) chk("stable", dut_rec(), held);
   endtask

   task automatic retire(input logic [31:0] pc, input logic [31:0] ins, input logic [4:0] rd,
                         input logic [31:0] rdat, input logic rfwe, input logic re,
                         input logic we, input logic [31:0] ra, input logic [31:0] wa,
                         input logic [31:0] wd, input logic [1:0] sz);
      update_i = 1; pc_i = pc; instr_i = ins; rd_i = rd; rd_data_i = rdat;
      rf_we_i = rfwe; mem_re_i = re; mem_we_i = we; mem_raddr_i = ra;
      mem_waddr_i = wa; mem_wdata_i = wd; st_size_i = sz;
   endtask

   task automatic rand_retire(input bit allow_pc0);
      logic [31:0] ins = $urandom;
      logic [31:0] pc = $urandom;
      if (ins == END_I) ins = 32'h00000013;
      if (pc == 0 || (allow_pc0 && $urandom_range(0, 7) == 0)) pc = allow_pc0 ? 32'h0 : 32'h4;
      retire(pc, ins, 5'($urandom), $urandom, 1'($urandom), 1'($urandom),
             ($urandom_range(0, 3) == 0), $urandom, $urandom, $urandom, 2'($urandom));
   endtask

   task automatic idle();
      update_i = 0;
   endtask

   task automatic do_reset();
      idle();
      rstn = 0;
      step();
      rstn = 1;
   endtask

   initial begin
      // Reset state
      do_reset();
      chk("rst_level", level_o, 0);
      chk("rst_valid", rec_valid_o, 0);

      // ADDI into REG record
      rec_ready_i = 1;
      retire(32'h80000000, 32'h01000293, 5, 32'h10, 1, 0, 0, 0, 0, 0, 0);
      step();
      chk("addi_kind", rec_kind_o, 1);
      chk("addi_rd", rec_rd_o, 5);
      chk("addi_data", rec_data_o, 32'h10);
      chk("addi_addr", rec_addr_o, 0);

      // SB masks data to a byte
      retire(32'h80000004, 32'h00a10023, 0, 0, 0, 0, 1, 0, 32'h80001003, 32'hDEADBEEF, 0);
      step();
      chk("sb_kind", rec_kind_o, 3);
      chk("sb_data", rec_data_o, 32'h000000EF);
      chk("sb_size", rec_size_o, 0);
      chk("sb_addr", rec_addr_o, 32'h80001003);

      // LW with rd=0 degrades to PLAIN
      retire(32'h80000008, 32'h00012003, 0, 32'h55, 1, 1, 0, 32'h80002000, 0, 0, 0);
      step();
      chk("lw0_kind", rec_kind_o, 0);
      chk("lw0_data", rec_data_o, 0);

      // Half and size-3 stores
      retire(32'h8000000c, 32'h00a11023, 0, 0, 0, 0, 1, 0, 32'h10, 32'hCAFEF00D, 1);
      step();
      chk("sh_data", rec_data_o, 32'h0000F00D);
      retire(32'h80000010, 32'h00a12023, 0, 0, 0, 0, 1, 0, 32'h14, 32'hCAFEF00D, 3);
      step();
      chk("sz3_data", rec_data_o, 32'hCAFEF00D);
      idle();
      repeat (2) step();

      // Overflow: 20 retires into a stalled FIFO
      rec_ready_i = 0;
      for (int i = 0; i < 20; i++) begin
         rand_retire(0);
         step();
      end
      chk("full_level", level_o, 16);
      chk("full_drop", drop_cnt_o, 4);
      rec_ready_i = 1;
      rand_retire(0);
      step();
      chk("pushpop_drop", drop_cnt_o, 4);
      chk("pushpop_level", level_o, 16);
      idle();
      repeat (18) step();

      // Reset while holding 5 records
      rec_ready_i = 0;
      for (int i = 0; i < 5; i++) begin
         rand_retire(0);
         step();
      end
      chk("pre_rst_level", level_o, 5);
      do_reset();
      chk("mid_rst_level", level_o, 0);
      chk("mid_rst_valid", rec_valid_o, 0);
      chk("mid_rst_drop", drop_cnt_o, 0);
      rand_retire(0);
      step();
      chk("post_rst_capture", rec_valid_o, 1);
      do_reset();

      // Random traffic with ready toggling
      for (int i = 0; i < 200; i++) begin
         rec_ready_i = 1'($urandom);
         if ($urandom_range(0, 3) == 0) idle(); else rand_retire(1);
         step();
      end
      rec_ready_i = 1;
      idle();
      repeat (18) step();
      do_reset();

      // End of test at level 3
      rec_ready_i = 0;
      for (int i = 0; i < 3; i++) begin
         rand_retire(0);
         step();
      end
      rec_ready_i = 1;
      retire(32'h80000100, END_I, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step();
      for (int i = 0; i < 20 && !done_o; i++) begin
         rand_retire(0);
         step();
      end
      chk("eot_done", done_o, 1);
      chk("eot_valid", rec_valid_o, 0);
      rand_retire(0);
      repeat (3) step();
      chk("done_hold", done_o, 1);
      do_reset();
      chk("done_cleared", done_o, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
